// File: rtl/delta_pkg.sv
// Shared encoder state encoding, used by the RTL and the bench.
package delta_pkg;
    typedef enum logic {S_FIRST = 1'b0, S_RUN = 1'b1} state_e;
endpackage

// File: rtl/delta_out_slice.sv
// Single-entry valid/ready output register for the delta payload.
// Latency: 1 cycle from load to out_valid.
// Backpressure: payload held stable while out_valid && !out_ready; clr drops it.
module delta_out_slice #(
    parameter int             PW       = 9,
    parameter logic [PW-1:0]  CLR_KEEP = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic [PW-1:0] load_dat,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [PW-1:0] dat
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dat       <= '0;
        end else if (clr) begin
            // Pending entry is dropped; only the bits in CLR_KEEP survive.
            out_valid <= 1'b0;
            dat       <= dat & CLR_KEEP;
        end else if (load) begin
            out_valid <= 1'b1;
            dat       <= load_dat;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/delta_encoder.sv
// Streaming first-difference encoder; optional out_ovf with DELTA_ENC_OVF_EN.
// Latency: 1 cycle, 1 sample/cycle while out_ready is high.
// Backpressure: in_ready = !clr && (!out_valid || out_ready).
`ifndef __DELTA_ENCODER_SV__
`define __DELTA_ENCODER_SV__
module delta_encoder
    import delta_pkg::*;
#(
    parameter int  DW   = 8,
    parameter int  CW   = 16,
    parameter type dw_t = logic [DW-1:0]
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  dw_t           in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output dw_t           out_delta,
    output logic          out_first,
    output logic [CW-1:0] out_cnt
`ifdef DELTA_ENC_OVF_EN
    ,
    output logic          out_ovf
`endif
);
`ifdef DELTA_ENC_OVF_EN
    localparam int PW = DW + 2;
`else
    localparam int PW = DW + 1;
`endif
    localparam logic [PW-1:0] KEEP_DELTA = {{(PW-DW){1'b0}}, {DW{1'b1}}};

    state_e        state, state_nxt;
    dw_t           prev;
    dw_t           delta_nxt;
    logic          first_nxt;
    logic          in_xfer, out_xfer;
    logic [PW-1:0] load_dat, slice_dat;

    assign in_ready = !clr && (!out_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FIRST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr)          state_nxt = S_FIRST;
        else if (in_xfer) state_nxt = S_RUN;
    end

    always_comb begin
        delta_nxt = in_data - prev;
        first_nxt = (state == S_FIRST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            out_cnt <= '0;
        end else if (clr) begin
            prev    <= '0;
            out_cnt <= '0;
        end else begin
            if (in_xfer)  prev    <= in_data;
            if (out_xfer) out_cnt <= out_cnt + CW'(1);
        end
    end

`ifdef DELTA_ENC_OVF_EN
    logic [DW:0] diff_s;
    logic        ovf_nxt;
    // Sign-extended subtract: overflow when the top two bits disagree.
    always_comb begin
        diff_s  = {in_data[DW-1], in_data} - {prev[DW-1], prev};
        ovf_nxt = (diff_s[DW] != diff_s[DW-1]) && !first_nxt;
    end
    assign load_dat = {ovf_nxt, first_nxt, delta_nxt};
    assign out_ovf  = slice_dat[DW+1];
`else
    assign load_dat = {first_nxt, delta_nxt};
`endif

    delta_out_slice #(
        .PW       (PW),
        .CLR_KEEP (KEEP_DELTA)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .load      (in_xfer),
        .load_dat  (load_dat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dat       (slice_dat)
    );

    assign out_delta = slice_dat[DW-1:0];
    assign out_first = slice_dat[DW];
endmodule
`endif
